// File: rtl/hd_program_loader_pkg.sv
// Shared control encodings, FSM states and size defaults for the HD program loader.
package hd_program_loader_pkg;

   localparam logic [1:0] CTRL_ON  = 2'b01;
   localparam logic [1:0] CTRL_OFF = 2'b00;

   localparam int TRACK_SIZE_DEF = 200;
   // Must track the instruction memory's block size constant.
   localparam int BLOCK_SIZE_DEF = 200;
   localparam int LEN_W_DEF      = 16;

   typedef enum logic [2:0] {
      IDLE,
      HDR_REQ,
      HDR_WAIT,
      XFER,
      DRAIN,
      FINISH
   } state_t;

endpackage

// File: rtl/hd_xor_fold.sv
// XOR-fold checksum accumulator: each 32-bit word is folded to W bits and XORed
// into the running value. Only used when HD_PROGRAM_LOADER_CHECKSUM_EN is defined.
module hd_xor_fold
   import hd_program_loader_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   input  logic [31:0]  data,
   output logic [W-1:0] acc
);

   localparam int CHUNKS = (32 + W - 1) / W;
   localparam int PAD_W  = CHUNKS * W;

   logic [PAD_W-1:0] padded;
   logic [W-1:0]     part [CHUNKS+1];

   // Zero-pad the top chunk when W does not divide 32.
   assign padded  = PAD_W'(data);
   assign part[0] = '0;

   for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_fold
      assign part[gi+1] = part[gi] ^ padded[gi*W +: W];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc ^ part[CHUNKS];
      end
   end

endmodule

// File: rtl/hd_program_loader.sv
// Reads a program track (header + N words) from the HD model and streams it to
// instruction memory. Optional payload checksum: define HD_PROGRAM_LOADER_CHECKSUM_EN.
module hd_program_loader
   import hd_program_loader_pkg::*;
#(
   parameter int TRACK_SIZE = TRACK_SIZE_DEF,
   parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
   parameter int LEN_W      = LEN_W_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] track,
   output logic [31:0] hd_addr,
   output logic        hd_rd,
   input  logic [31:0] hd_data,
   output logic [31:0] entradaDeInstrucao,
   output logic [1:0]  controleSalvaInstrucao,
   output logic [1:0]  ControleFimDeLeitura,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [31:0] TRACK_W   = 32'(TRACK_SIZE);
   localparam logic [31:0] MAX_LEN_W =
      32'((BLOCK_SIZE < TRACK_SIZE - 1) ? BLOCK_SIZE : TRACK_SIZE - 1);

   state_t           state_reg;
   logic [LEN_W-1:0] remain_reg;
   logic             rd_pipe_reg;
   logic [LEN_W-1:0] hdr_len;
   logic             too_long;
   logic             payload_valid;
   logic             sum_ok;

   assign hdr_len  = hd_data[LEN_W-1:0];
   assign too_long = (32'(hdr_len) > MAX_LEN_W);
   // rd_pipe_reg marks cycles where hd_data carries a word; the header is excluded by state.
   assign payload_valid = rd_pipe_reg && ((state_reg == XFER) || (state_reg == DRAIN));

`ifdef HD_PROGRAM_LOADER_CHECKSUM_EN
   localparam int SUM_W = 32 - LEN_W;

   logic [SUM_W-1:0] sum_hdr_reg;
   logic [SUM_W-1:0] sum_acc;

   hd_xor_fold #(.W(SUM_W)) u_fold (
      .clock (clock),
      .reset (reset),
      .clear (state_reg == HDR_WAIT),
      .en    (payload_valid),
      .data  (hd_data),
      .acc   (sum_acc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sum_hdr_reg <= '0;
      end else if (state_reg == HDR_WAIT) begin
         sum_hdr_reg <= hd_data[31:LEN_W];
      end
   end

   assign sum_ok = (sum_acc == sum_hdr_reg);
`else
   assign sum_ok = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg              <= IDLE;
         remain_reg             <= '0;
         rd_pipe_reg            <= 1'b0;
         hd_addr                <= '0;
         hd_rd                  <= 1'b0;
         entradaDeInstrucao     <= '0;
         controleSalvaInstrucao <= CTRL_OFF;
         ControleFimDeLeitura   <= CTRL_OFF;
         busy                   <= 1'b0;
         done                   <= 1'b0;
         error                  <= 1'b0;
      end else begin
         rd_pipe_reg            <= hd_rd;
         controleSalvaInstrucao <= CTRL_OFF;
         error                  <= 1'b0;

         if (payload_valid) begin
            entradaDeInstrucao     <= hd_data;
            controleSalvaInstrucao <= CTRL_ON;
         end

         case (state_reg)
            IDLE: begin
               if (start) begin
                  hd_addr   <= track * TRACK_W;
                  hd_rd     <= 1'b1;
                  busy      <= 1'b1;
                  state_reg <= HDR_REQ;
               end
            end

            HDR_REQ: begin
               hd_rd     <= 1'b0;
               state_reg <= HDR_WAIT;
            end

            HDR_WAIT: begin
               if (too_long) begin
                  error     <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else if (hdr_len == '0) begin
                  state_reg <= FINISH;
               end else begin
                  hd_addr    <= hd_addr + 32'd1;
                  hd_rd      <= 1'b1;
                  remain_reg <= hdr_len - LEN_W'(1);
                  state_reg  <= XFER;
               end
            end

            XFER: begin
               if (remain_reg != '0) begin
                  hd_addr    <= hd_addr + 32'd1;
                  remain_reg <= remain_reg - LEN_W'(1);
               end else begin
                  hd_rd     <= 1'b0;
                  state_reg <= DRAIN;
               end
            end

            // HD latency is fixed, so the last word is presented on this edge.
            DRAIN: begin
               state_reg <= FINISH;
            end

            // First FINISH edge raises the end pulse, the second retires it.
            FINISH: begin
               if (ControleFimDeLeitura == CTRL_OFF) begin
                  ControleFimDeLeitura <= CTRL_ON;
                  done                 <= sum_ok;
                  error                <= !sum_ok;
               end else begin
                  ControleFimDeLeitura <= CTRL_OFF;
                  done                 <= 1'b0;
                  busy                 <= 1'b0;
                  state_reg            <= IDLE;
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
